// File: rtl/isa_pkg.sv
// Shared fetch-path types and constants: instruction width, fetch FSM states
// and the default reset PC.
package isa_pkg;

  localparam int INSTR_W      = 32;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the valid/ready
// stream of fetched words towards decode.
interface inst_fetch_ctrl_if #(
  parameter int ADDR_W = 10
) ();
  import isa_pkg::*;

  logic [31:0]         imem_addr;
  logic                imem_en;
  logic [INSTR_W-1:0]  imem_rdata;
  logic                if_valid;
  logic                if_ready;
  logic [INSTR_W-1:0]  if_instr;
  logic [ADDR_W-1:0]   if_pc;

  modport master (
    output imem_addr, imem_en, if_valid, if_instr, if_pc,
    input  imem_rdata, if_ready
  );

  modport slave (
    input  imem_addr, imem_en, if_valid, if_instr, if_pc,
    output imem_rdata, if_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl_fetch_buf.sv
// Two-entry in-order FIFO with flush. The head lives in entry 0 so the output
// is a plain register and holds its last value once the FIFO drains.
module fetch_buf #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] ent_reg [2];
  logic [1:0]   count_reg;
  logic [1:0]   wr_idx;

  // After a pop the remaining entry shifts down, so the write slot moves with it.
  assign wr_idx = count_reg - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) ent_reg[i] <= '0;
      count_reg <= 2'd0;
    end else if (flush) begin
      count_reg <= 2'd0;
    end else begin
      // Shift only when a second entry exists; otherwise entry 0 keeps its old value.
      if (pop && count_reg == 2'd2) ent_reg[0] <= ent_reg[1];
      if (push) ent_reg[wr_idx[0]] <= din;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = ent_reg[0];
  assign valid = (count_reg != 2'd0);
  assign count = count_reg;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads one word per cycle from a
// combinational memory and queues {instr, pc} towards decode.
module inst_fetch_ctrl
  import isa_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        fetch_state,
  inst_fetch_ctrl_if.master bus
);

  localparam int BUF_W = INSTR_W + ADDR_W;

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              fetch_en;
  logic              pop;
  logic [1:0]        buf_count;
  logic              buf_valid;
  logic [BUF_W-1:0]  buf_dout;

  // A redirect flushes the buffer, so a handshake in that cycle is not a delivery.
  assign pop      = buf_valid && bus.if_ready && !redirect_valid;
  assign fetch_en = (state_reg == RUN) && !redirect_valid &&
                    ((int'(buf_count) < BUF_DEPTH) || pop);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (halt_req) state_next = HALT;
      HALT:    if (start)    state_next = RUN;
      default:               state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid) pc_next = redirect_pc;
    else if (fetch_en)  pc_next = pc_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  fetch_buf #(.W(BUF_W)) u_fetch_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (fetch_en),
    .pop   (pop),
    .din   ({bus.imem_rdata, pc_reg}),
    .dout  (buf_dout),
    .valid (buf_valid),
    .count (buf_count)
  );

  assign bus.imem_addr = {{(32-ADDR_W){1'b0}}, pc_reg};
  assign bus.imem_en   = fetch_en;
  assign bus.if_valid  = buf_valid;
  assign bus.if_instr  = buf_dout[BUF_W-1:ADDR_W];
  assign bus.if_pc     = buf_dout[ADDR_W-1:0];
  assign fetch_state   = state_reg;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: a fixed vector table, hand-written
// redirect/wrap/reset sequences and a randomized run against a queue model.
module tb_inst_fetch_ctrl;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          halt_req = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [1:0]    fetch_state;
  logic          rdy = 1'b0;
  logic [31:0]   mem [DEPTH];

  inst_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

  assign bus.if_ready   = rdy;
  assign bus.imem_rdata = mem[bus.imem_addr[AW-1:0]];

  inst_fetch_ctrl #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_state    (fetch_state),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: PC, state number and an ordered queue of fetched words.
  typedef struct packed {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t mq[$];
  ent_t m_last;
  int   m_pc;
  int   m_state;
  bit   m_en;
  bit   m_pop;

  typedef struct {
    int st, hr, rv, rpc, rd;
    int e_en, e_addr, e_valid, e_pc, e_state;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last  = '0;
    m_pc    = 0;
    m_state = 0;
  endtask

  task automatic drive(input int st, input int hr, input int rv, input int rpc, input int rd);
    start          = st[0];
    halt_req       = hr[0];
    redirect_valid = rv[0];
    redirect_pc    = rpc[AW-1:0];
    rdy            = rd[0];
  endtask

  task automatic check_model();
    bit ev;
    ev = (mq.size() > 0);
    if (ev) m_last = mq[0];
    m_pop = ev && rdy && !redirect_valid;
    m_en  = (m_state == 1) && !redirect_valid && (mq.size() < 2 || m_pop);
    chk("imem_en",     64'(bus.imem_en),   64'(m_en));
    chk("imem_addr",   64'(bus.imem_addr), 64'(m_pc));
    chk("if_valid",    64'(bus.if_valid),  64'(ev));
    chk("if_instr",    64'(bus.if_instr),  64'(m_last.instr));
    chk("if_pc",       64'(bus.if_pc),     64'(m_last.pc));
    chk("fetch_state", 64'(fetch_state),   64'(m_state));
  endtask

  task automatic tick();
    if (redirect_valid) begin
      m_pc = int'(redirect_pc);
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_en) begin
        mq.push_back({mem[m_pc], m_pc[AW-1:0]});
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
    if (m_state == 0 && start)         m_state = 1;
    else if (m_state == 1 && halt_req) m_state = 2;
    else if (m_state == 2 && start)    m_state = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();

    // start, stall decode, release, redirect with 3,4 buffered, halt, restart
    tbl[0]  = '{1,0,0,0,0,  0,0,0,0,0};
    tbl[1]  = '{0,0,0,0,0,  1,0,0,0,1};
    tbl[2]  = '{0,0,0,0,0,  1,1,1,0,1};
    tbl[3]  = '{0,0,0,0,0,  0,2,1,0,1};
    tbl[4]  = '{0,0,0,0,0,  0,2,1,0,1};
    tbl[5]  = '{0,0,0,0,0,  0,2,1,0,1};
    tbl[6]  = '{0,0,0,0,0,  0,2,1,0,1};
    tbl[7]  = '{0,0,0,0,1,  1,2,1,0,1};
    tbl[8]  = '{0,0,0,0,1,  1,3,1,1,1};
    tbl[9]  = '{0,0,0,0,1,  1,4,1,2,1};
    tbl[10] = '{0,0,1,12,1, 0,5,1,3,1};
    tbl[11] = '{0,0,0,0,1,  1,12,0,3,1};
    tbl[12] = '{0,1,0,0,1,  1,13,1,12,1};
    tbl[13] = '{0,0,0,0,0,  0,14,1,13,2};
    tbl[14] = '{0,0,0,0,1,  0,14,1,13,2};
    tbl[15] = '{0,0,0,0,1,  0,14,0,13,2};
    tbl[16] = '{1,0,0,0,1,  0,14,0,13,2};
    tbl[17] = '{0,0,0,0,1,  1,14,0,13,1};
    tbl[18] = '{0,0,0,0,1,  1,15,1,14,1};

    @(negedge clk);
    do_reset();
    chk("reset_if_instr", 64'(bus.if_instr), 64'd0);
    chk("reset_if_pc",    64'(bus.if_pc),    64'd0);

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].st, tbl[i].hr, tbl[i].rv, tbl[i].rpc, tbl[i].rd);
      #1;
      check_model();
      chk($sformatf("tbl%0d_en", i),    64'(bus.imem_en),   64'(tbl[i].e_en));
      chk($sformatf("tbl%0d_addr", i),  64'(bus.imem_addr), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_valid", i), 64'(bus.if_valid),  64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_state", i), 64'(fetch_state),   64'(tbl[i].e_state));
      if (i > 0) chk($sformatf("tbl%0d_pc", i), 64'(bus.if_pc), 64'(tbl[i].e_pc));
      if (tbl[i].e_valid != 0)
        chk($sformatf("tbl%0d_instr", i), 64'(bus.if_instr), 64'(mem[tbl[i].e_pc]));
      tick();
    end

    // Redirect to the last word: delivery wraps 1023 -> 0.
    drive(0, 0, 1, DEPTH - 1, 1); #1; check_model(); tick();
    drive(0, 0, 0, 0, 1);         #1; check_model();
    chk("wrap_gap_valid", 64'(bus.if_valid), 64'd0);
    tick();
    #1; check_model();
    chk("wrap_pc_last", 64'(bus.if_pc), 64'(DEPTH - 1));
    tick();
    #1; check_model();
    chk("wrap_pc_zero", 64'(bus.if_pc), 64'd0);
    chk("wrap_instr",   64'(bus.if_instr), 64'(mem[0]));
    tick();

    // Fill the buffer, then drop rst_n mid-cycle.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0); #1; check_model(); tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset_valid", 64'(bus.if_valid),  64'd0);
    chk("areset_state", 64'(fetch_state),   64'd0);
    chk("areset_addr",  64'(bus.imem_addr), 64'd0);
    chk("areset_en",    64'(bus.imem_en),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1); #1; check_model(); tick();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      int rpc;
      rpc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 4, DEPTH - 1))
                                        : int'($urandom_range(0, DEPTH - 1));
      drive(int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 9) == 0), rpc, int'($urandom_range(0, 3) != 0));
      #1;
      check_model();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
